irq_controller: RTL and testbench

- Interrupt capture and delivery stage that sits directly upstream of the CPU's priority interrupt encoder.
- Synchronises the raw timer, UART0 and MMU request lines, latches them per source as edge or level, applies a software mask and a global enable, and presents exactly one held request to the encoder.
- That request stays stable until the CPU acknowledges it.
- Software configures and inspects the block through a small 4-register port.

---
 rtl/irq_pkg.sv | 36 +++
 rtl/irq_capture.sv | 49 ++++
 rtl/irq_controller.sv | 153 +++++++++++++++
 tb/tb_irq_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, state type and priority helpers for the interrupt controller.
package irq_pkg;

    localparam int unsigned NSRC  = 7;
    localparam int unsigned IDX_W = $clog2(NSRC);

    localparam int unsigned IRQ_TIMER3 = 6;
    localparam int unsigned IRQ_TIMER2 = 5;
    localparam int unsigned IRQ_TIMER1 = 4;
    localparam int unsigned IRQ_TIMER0 = 3;
    localparam int unsigned IRQ_RX0    = 2;
    localparam int unsigned IRQ_TX0    = 1;
    localparam int unsigned IRQ_MMU    = 0;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} irq_state_t;

    // Highest set bit wins; bit 6 (timer3) is the highest priority.
    function automatic logic [IDX_W-1:0] prio_winner(input logic [NSRC-1:0] v);
        logic [IDX_W-1:0] w;
        w = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) w = IDX_W'(i);
        end
        return w;
    endfunction

    function automatic logic [NSRC-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NSRC-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/irq_capture.sv
// Per-source capture: optional 2-flop synchroniser (IRQ_SYNC_EN), edge/level detect, pending bit.
module irq_capture (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic level,
    input  logic clr,
    output logic pend,
    output logic pend_next
);

    logic s;
    logic prev_q;
    logic pend_q;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign s = sync_q[1];
`else
    assign s = raw;
`endif

    // A new edge beats a clear arriving in the same cycle.
    always_comb begin
        pend_next = level ? s : ((s & ~prev_q) | (pend_q & ~clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= s;
            pend_q <= pend_next;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt capture/delivery stage feeding the CPU priority encoder.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on every raw request line.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [NSRC-1:0] MODE_RST = 7'h01
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] timer_in,
    input  logic [1:0] serial0_in,
    input  logic       mmu_in,
    input  logic       ack_i,
    input  logic       we_i,
    input  logic [1:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic [3:0] timer_out,
    output logic [1:0] serial0_out,
    output logic       mmu_out,
    output logic       enabled,
    output logic       irq_pending
);

    logic [NSRC-1:0] raw;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic            ctrl_q, ctrl_d;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] pend, pend_d;
    logic [NSRC-1:0] masked;
    logic [NSRC-1:0] req_q;
    logic [IDX_W-1:0] win_q, winner;
    irq_state_t      state_q;
    logic            cancel;
    logic            pending_q;
    logic            unused_dat;

    assign raw        = {timer_in, serial0_in, mmu_in};
    assign unused_dat = dat_i[7];

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        ctrl_d = ctrl_q;
        w1c    = '0;
        if (we_i) begin
            unique case (adr_i)
                REG_MASK: mask_d = dat_i[NSRC-1:0];
                REG_PEND: w1c    = dat_i[NSRC-1:0];
                REG_MODE: mode_d = dat_i[NSRC-1:0];
                REG_CTRL: ctrl_d = dat_i[0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mask_q <= '0;
            mode_q <= MODE_RST;
            ctrl_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            mode_q <= mode_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign clr = w1c | ((state_q == PRESENT && ack_i) ? onehot(win_q) : '0);

    for (genvar i = 0; i < NSRC; i++) begin : g_cap
        irq_capture u_cap (
            .clk       (clk_i),
            .rst_n     (rst_i),
            .raw       (raw[i]),
            .level     (mode_q[i]),
            .clr       (clr[i]),
            .pend      (pend[i]),
            .pend_next (pend_d[i])
        );
    end

    assign masked = pend & mask_q;
    assign winner = prio_winner(masked);

    // Judge withdrawal on next-state values so a request never outlives its cause by a cycle.
    assign cancel = !mask_d[win_q] || !pend_d[win_q] || !ctrl_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            req_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ctrl_q && |masked) begin
                        win_q   <= winner;
                        req_q   <= onehot(winner);
                        state_q <= PRESENT;
                    end else begin
                        req_q <= '0;
                    end
                end
                PRESENT: begin
                    if (ack_i) begin
                        req_q   <= '0;
                        state_q <= GAP;
                    end else if (cancel) begin
                        req_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    req_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= |(pend_d & mask_d);
        end
    end

    always_comb begin
        dat_o = '0;
        unique case (adr_i)
            REG_MASK: dat_o = {1'b0, mask_q};
            REG_PEND: dat_o = {1'b0, pend};
            REG_MODE: dat_o = {1'b0, mode_q};
            REG_CTRL: dat_o = {7'b0, ctrl_q};
            default:  dat_o = '0;
        endcase
    end

    assign timer_out   = req_q[6:3];
    assign serial0_out = req_q[2:1];
    assign mmu_out     = req_q[0];
    assign enabled     = ctrl_q;
    assign irq_pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
module tb_irq_controller;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [3:0] timer_in = '0;
    logic [1:0] serial0_in = '0;
    logic       mmu_in = 1'b0;
    logic       ack_i = 1'b0;
    logic       we_i = 1'b0;
    logic [1:0] adr_i = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic [3:0] timer_out;
    logic [1:0] serial0_out;
    logic       mmu_out;
    logic       enabled;
    logic       irq_pending;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .timer_in    (timer_in),
        .serial0_in  (serial0_in),
        .mmu_in      (mmu_in),
        .ack_i       (ack_i),
        .we_i        (we_i),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .timer_out   (timer_out),
        .serial0_out (serial0_out),
        .mmu_out     (mmu_out),
        .enabled     (enabled),
        .irq_pending (irq_pending)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        adr_i = a;
        #1;
        check(tag, dat_o, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we_i  = 1'b1;
        adr_i = a;
        dat_i = d;
        step(1);
        we_i  = 1'b0;
    endtask

    initial begin
        step(3);
        rst_i = 1'b1;
        step(1);
        check("rst_mask", {1'b0, 7'h00}, 8'h00 | dat_o & 8'h00);
        check_reg("rst_mask_reg", REG_MASK, 8'h00);
        check_reg("rst_pend_reg", REG_PEND, 8'h00);
        check_reg("rst_mode_reg", REG_MODE, 8'h01);
        check_reg("rst_ctrl_reg", REG_CTRL, 8'h00);
        check("rst_outs", {1'b0, timer_out, serial0_out, mmu_out}, 8'h00);
        check("rst_en_pend", {6'b0, enabled, irq_pending}, 8'h00);

        // 1: single timer2 edge, ack, gap
        wr(REG_MASK, 8'h7F);
        wr(REG_CTRL, 8'h01);
        check("t1_enabled", {7'b0, enabled}, 8'h01);
        timer_in = 4'b0100;
        step(1);
        timer_in = 4'b0000;
        step(SYNC_LAT);
        check_reg("t1_pend", REG_PEND, 8'h20);
        check("t1_not_yet", {4'b0, timer_out}, 8'h00);
        step(1);
        check("t1_present", {4'b0, timer_out}, 8'h04);
        ack_i = 1'b1;
        step(1);
        ack_i = 1'b0;
        check("t1_gap", {4'b0, timer_out}, 8'h00);
        check_reg("t1_pend_clr", REG_PEND, 8'h00);
        step(1);
        check("t1_idle", {4'b0, timer_out}, 8'h00);

        // 2: priority and hold while presented
        timer_in   = 4'b0001;
        serial0_in = 2'b10;
        step(1 + SYNC_LAT);
        step(1);
        check("t2_timer0", {2'b0, timer_out, serial0_out}, 8'h04);
        timer_in = 4'b1001;
        step(1 + SYNC_LAT);
        step(1);
        check("t2_hold", {4'b0, timer_out}, 8'h01);
        check_reg("t2_pend", REG_PEND, 8'h4C);
        ack_i = 1'b1;
        step(1);
        ack_i = 1'b0;
        check("t2_gap", {4'b0, timer_out}, 8'h00);
        step(1);
        check("t2_idle", {4'b0, timer_out}, 8'h00);
        step(1);
        check("t2_timer3", {2'b0, timer_out, serial0_out}, 8'h20);
        ack_i = 1'b1;
        step(1);
        ack_i = 1'b0;
        step(2);
        check("t2_rx", {2'b0, timer_out, serial0_out}, 8'h02);
        ack_i = 1'b1;
        step(1);
        ack_i      = 1'b0;
        timer_in   = 4'b0000;
        serial0_in = 2'b00;
        step(2 + SYNC_LAT);
        check_reg("t2_pend_empty", REG_PEND, 8'h00);

        // 3: level-mode MMU survives ack
        mmu_in = 1'b1;
        step(1 + SYNC_LAT);
        check_reg("t3_pend", REG_PEND, 8'h01);
        step(1);
        check("t3_present", {7'b0, mmu_out}, 8'h01);
        ack_i = 1'b1;
        step(1);
        ack_i = 1'b0;
        check("t3_gap", {7'b0, mmu_out}, 8'h00);
        check_reg("t3_pend_kept", REG_PEND, 8'h01);
        step(2);
        check("t3_reassert", {7'b0, mmu_out}, 8'h01);
        mmu_in = 1'b0;
        step(1 + SYNC_LAT);
        check_reg("t3_pend_drop", REG_PEND, 8'h00);
        check("t3_out_drop", {7'b0, mmu_out}, 8'h00);

        // 4: masking the presented TX request withdraws it
        serial0_in = 2'b01;
        step(1 + SYNC_LAT);
        step(1);
        check("t4_present", {6'b0, serial0_out}, 8'h01);
        check("t4_irq_pending", {7'b0, irq_pending}, 8'h01);
        wr(REG_MASK, 8'h7D);
        check("t4_withdrawn", {6'b0, serial0_out}, 8'h00);
        check("t4_irq_pending_mask", {7'b0, irq_pending}, 8'h00);
        check("t4_state", 8'(dut.state_q), 8'(IDLE));
        step(1);
        check("t4_stays_off", {6'b0, serial0_out}, 8'h00);
        serial0_in = 2'b00;
        wr(REG_PEND, 8'h02);
        check_reg("t4_w1c", REG_PEND, 8'h00);

        // 5: new edge beats a same-cycle W1C
        wr(REG_MASK, 8'h00);
        timer_in = 4'b0001;
        step(1 + SYNC_LAT);
        timer_in = 4'b0000;
        step(1);
        check_reg("t5_pend", REG_PEND, 8'h08);
        timer_in = 4'b0001;
        step(SYNC_LAT);
        wr(REG_PEND, 8'h08);
        check_reg("t5_set_wins", REG_PEND, 8'h08);
        wr(REG_PEND, 8'h08);
        check_reg("t5_w1c", REG_PEND, 8'h00);
        timer_in = 4'b0000;
        step(1 + SYNC_LAT);

        // 6: asynchronous reset mid-PRESENT
        wr(REG_MASK, 8'h7F);
        timer_in = 4'b0010;
        step(1 + SYNC_LAT);
        timer_in = 4'b0000;
        step(1);
        check("t6_present", {4'b0, timer_out}, 8'h02);
        #2;
        rst_i = 1'b0;
        #1;
        check("t6_outs", {1'b0, timer_out, serial0_out, mmu_out}, 8'h00);
        check("t6_en_pend", {6'b0, enabled, irq_pending}, 8'h00);
        check_reg("t6_mask", REG_MASK, 8'h00);
        check_reg("t6_mode", REG_MODE, 8'h01);
        check_reg("t6_pend", REG_PEND, 8'h00);
        step(2);
        rst_i = 1'b1;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
